// File: rtl/microwave_controller.sv
// Microwave oven control FSM: sequences the min:sec countdown timer, gates the
// magnetron, reacts to door/start/stop events and produces a completion beep.
module microwave_controller #(
  parameter int unsigned BEEP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       key_valid,
  input  logic       timer_zero,
  output logic       timer_enable_n,
  output logic       timer_load_n,
  output logic       timer_clear_n,
  output logic       magnetron_on,
  output logic       done_beep,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] BEEP_LAST = 8'(BEEP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] beep_cnt_q, beep_cnt_d;
  logic       start_q, stop_q;
  logic       start_edge, stop_edge;
  logic       cook_ok;

  // Button edge detection; the history registers reset high so a button held
  // through reset release does not register as a press.
  always_comb begin
    start_edge = start & ~start_q;
    stop_edge  = stop  & ~stop_q;
    cook_ok    = start_edge & door_closed & ~timer_zero;
  end

  // State, beep counter and button history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      beep_cnt_q <= '0;
      start_q    <= 1'b1;
      stop_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      beep_cnt_q <= beep_cnt_d;
      start_q    <= start;
      stop_q     <= stop;
    end
  end

  // Next-state and beep counter logic; counter sits at 0 outside DONE so it
  // starts from 0 on every entry into DONE.
  always_comb begin
    state_d    = state_q;
    beep_cnt_d = '0;
    case (state_q)
      IDLE: begin
        if (cook_ok) state_d = COOK;
      end
      COOK: begin
        if (timer_zero)        state_d = DONE;
        else if (!door_closed) state_d = PAUSE;
        else if (stop_edge)    state_d = PAUSE;
      end
      PAUSE: begin
        if (stop_edge)    state_d = IDLE;
        else if (cook_ok) state_d = COOK;
      end
      DONE: begin
        beep_cnt_d = (beep_cnt_q != '1) ? beep_cnt_q + 8'd1 : beep_cnt_q;
        if ((beep_cnt_q == BEEP_LAST) || stop_edge || !door_closed) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from state; timer load/clear are combinational on inputs.
  always_comb begin
    state          = state_q;
    magnetron_on   = (state_q == COOK);
    timer_enable_n = ~(state_q == COOK);
    done_beep      = (state_q == DONE);
    timer_load_n   = ~(key_valid & (state_q == IDLE));
    timer_clear_n  = ~(reset | (stop_edge & ((state_q == IDLE) | (state_q == PAUSE))));
  end

endmodule

// File: tb/tb_microwave_controller.sv
// Testbench for microwave_controller: table-driven scenarios with a scoreboard
// queue of expected output vectors, compared at the falling clock edge.
module tb_microwave_controller;

  logic clk = 1'b0;
  logic reset, start, stop, door_closed, key_valid, timer_zero;
  logic       en_n0, ld_n0, clr_n0, mag0, beep0;
  logic [1:0] st0;
  logic       en_n1, ld_n1, clr_n1, mag1, beep1;
  logic [1:0] st1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  microwave_controller dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .door_closed(door_closed),
    .key_valid(key_valid), .timer_zero(timer_zero), .timer_enable_n(en_n0),
    .timer_load_n(ld_n0), .timer_clear_n(clr_n0), .magnetron_on(mag0),
    .done_beep(beep0), .state(st0)
  );

  microwave_controller #(.BEEP_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .door_closed(door_closed),
    .key_valid(key_valid), .timer_zero(timer_zero), .timer_enable_n(en_n1),
    .timer_load_n(ld_n1), .timer_clear_n(clr_n1), .magnetron_on(mag1),
    .done_beep(beep1), .state(st1)
  );

  // Observed vector: {state, magnetron_on, done_beep, timer_enable_n, timer_load_n, timer_clear_n}
  logic [6:0] obs0, obs1;
  assign obs0 = {st0, mag0, beep0, en_n0, ld_n0, clr_n0};
  assign obs1 = {st1, mag1, beep1, en_n1, ld_n1, clr_n1};

  // One cycle of stimulus {reset,start,stop,door_closed,key_valid,timer_zero},
  // the state expected during that cycle and the expected Mealy outputs.
  typedef struct packed {
    logic [5:0] si;
    logic [1:0] es;
    logic       eld;
    logic       eclr;
  } step_t;

  typedef struct {
    string      tag;
    logic [6:0] v;
  } exp_t;

  step_t plan[$];
  exp_t  exp_q[$];

  function automatic void add(input logic [5:0] si, input logic [1:0] es,
                              input logic eld = 1'b1, input logic eclr = 1'b1);
    step_t p;
    p.si = si; p.es = es; p.eld = eld; p.eclr = eclr;
    plan.push_back(p);
  endfunction

  // Expected full output vector from the expected state (Moore decode) and Mealy bits.
  function automatic logic [6:0] expv(input step_t p);
    return {p.es, p.es == 2'd1, p.es == 2'd3, p.es != 2'd1, p.eld, p.eclr};
  endfunction

  task automatic test_reset();
    exp_t e;
    plan.delete();
    add(6'b100100, 2'd0, 1'b1, 1'b0);
    add(6'b100100, 2'd0, 1'b1, 1'b0);
    add(6'b000100, 2'd0);
    add(6'b000110, 2'd0, 1'b0, 1'b1);
    add(6'b000100, 2'd0);
    foreach (plan[i]) begin
      @(posedge clk); #1;
      {reset, start, stop, door_closed, key_valid, timer_zero} = plan[i].si;
      e.tag = $sformatf("reset[%0d]", i); e.v = expv(plan[i]); exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs0 !== e.v) begin
        errors++; $display("FAIL %s got %b want %b", e.tag, obs0, e.v);
      end
    end
  endtask

  task automatic test_normal_cook();
    exp_t e;
    plan.delete();
    add(6'b010100, 2'd0);
    add(6'b010100, 2'd1);
    add(6'b000100, 2'd1);
    add(6'b000101, 2'd1);
    for (int k = 0; k < 8; k++) add(6'b000100, 2'd3);
    add(6'b000100, 2'd0);
    add(6'b000100, 2'd0);
    foreach (plan[i]) begin
      @(posedge clk); #1;
      {reset, start, stop, door_closed, key_valid, timer_zero} = plan[i].si;
      e.tag = $sformatf("cook[%0d]", i); e.v = expv(plan[i]); exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs0 !== e.v) begin
        errors++; $display("FAIL %s got %b want %b", e.tag, obs0, e.v);
      end
    end
  endtask

  task automatic test_door_interlock();
    exp_t e;
    plan.delete();
    add(6'b010100, 2'd0);
    add(6'b000100, 2'd1);
    add(6'b000000, 2'd1);
    add(6'b010000, 2'd2);
    add(6'b000000, 2'd2);
    add(6'b000100, 2'd2);
    add(6'b010100, 2'd2);
    add(6'b000100, 2'd1);
    add(6'b001100, 2'd1);
    add(6'b000100, 2'd2);
    add(6'b001100, 2'd2, 1'b1, 1'b0);
    add(6'b000100, 2'd0);
    foreach (plan[i]) begin
      @(posedge clk); #1;
      {reset, start, stop, door_closed, key_valid, timer_zero} = plan[i].si;
      e.tag = $sformatf("door[%0d]", i); e.v = expv(plan[i]); exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs0 !== e.v) begin
        errors++; $display("FAIL %s got %b want %b", e.tag, obs0, e.v);
      end
    end
  endtask

  task automatic test_stop_cancel();
    exp_t e;
    plan.delete();
    add(6'b010100, 2'd0);
    add(6'b000100, 2'd1);
    add(6'b001100, 2'd1);
    add(6'b000100, 2'd2);
    add(6'b001100, 2'd2, 1'b1, 1'b0);
    add(6'b000100, 2'd0);
    add(6'b010100, 2'd0);
    add(6'b000100, 2'd1);
    add(6'b001100, 2'd1);
    add(6'b000100, 2'd2);
    add(6'b011100, 2'd2, 1'b1, 1'b0);
    add(6'b000100, 2'd0);
    add(6'b001100, 2'd0, 1'b1, 1'b0);
    add(6'b000100, 2'd0);
    foreach (plan[i]) begin
      @(posedge clk); #1;
      {reset, start, stop, door_closed, key_valid, timer_zero} = plan[i].si;
      e.tag = $sformatf("stop[%0d]", i); e.v = expv(plan[i]); exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs0 !== e.v) begin
        errors++; $display("FAIL %s got %b want %b", e.tag, obs0, e.v);
      end
    end
  endtask

  task automatic test_guards();
    exp_t e;
    plan.delete();
    add(6'b010101, 2'd0);
    add(6'b000101, 2'd0);
    add(6'b000100, 2'd0);
    add(6'b110100, 2'd0, 1'b1, 1'b0);
    add(6'b010100, 2'd0);
    add(6'b010100, 2'd0);
    add(6'b000100, 2'd0);
    add(6'b010100, 2'd0);
    add(6'b000110, 2'd1);
    add(6'b001100, 2'd1);
    add(6'b000110, 2'd2);
    add(6'b001100, 2'd2, 1'b1, 1'b0);
    add(6'b000100, 2'd0);
    foreach (plan[i]) begin
      @(posedge clk); #1;
      {reset, start, stop, door_closed, key_valid, timer_zero} = plan[i].si;
      e.tag = $sformatf("guard[%0d]", i); e.v = expv(plan[i]); exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs0 !== e.v) begin
        errors++; $display("FAIL %s got %b want %b", e.tag, obs0, e.v);
      end
    end
  endtask

  task automatic test_beep_abort();
    exp_t e;
    plan.delete();
    add(6'b010100, 2'd0);
    add(6'b000101, 2'd1);
    add(6'b000100, 2'd3);
    add(6'b000100, 2'd3);
    add(6'b001100, 2'd3);
    add(6'b000100, 2'd0);
    add(6'b010100, 2'd0);
    add(6'b000101, 2'd1);
    add(6'b000100, 2'd3);
    add(6'b000000, 2'd3);
    add(6'b000100, 2'd0);
    foreach (plan[i]) begin
      @(posedge clk); #1;
      {reset, start, stop, door_closed, key_valid, timer_zero} = plan[i].si;
      e.tag = $sformatf("abort[%0d]", i); e.v = expv(plan[i]); exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs0 !== e.v) begin
        errors++; $display("FAIL %s got %b want %b", e.tag, obs0, e.v);
      end
    end
  endtask

  task automatic test_beep1();
    exp_t e;
    plan.delete();
    add(6'b100100, 2'd0, 1'b1, 1'b0);
    add(6'b000100, 2'd0);
    add(6'b010100, 2'd0);
    add(6'b000101, 2'd1);
    add(6'b000100, 2'd3);
    add(6'b000100, 2'd0);
    add(6'b000100, 2'd0);
    foreach (plan[i]) begin
      @(posedge clk); #1;
      {reset, start, stop, door_closed, key_valid, timer_zero} = plan[i].si;
      e.tag = $sformatf("beep1[%0d]", i); e.v = expv(plan[i]); exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs1 !== e.v) begin
        errors++; $display("FAIL %s got %b want %b", e.tag, obs1, e.v);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    door_closed = 1'b1; key_valid = 1'b0; timer_zero = 1'b0;
    test_reset();
    test_normal_cook();
    test_door_interlock();
    test_stop_cancel();
    test_guards();
    test_beep_abort();
    test_beep1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
